// File: rtl/snoopy_assoc_cache_if.sv
// SystemBus: shared bus between L1 caches and the memory side.
//   rw_*  : one read or write transaction at a time. rw_valid is held by
//           the cache until the bus answers with a one-cycle rw_ready; on a
//           read, r_data is sampled in the rw_ready cycle.
//   inv_* : snoop invalidation. The bus holds inv_valid/inv_addr until the
//           cache answers with a one-cycle inv_ready.
// Modports: user (cache side), host (bus side).
interface SystemBus #(
    parameter int ADDR_WIDTH = 32,
    parameter int WIDTH      = 128,
    parameter int MASKW      = WIDTH / 8
);
    logic                  rw_valid;
    logic                  rw_ready;
    logic [ADDR_WIDTH-1:0] rw_addr;
    logic                  rw_we;
    logic [MASKW-1:0]      w_mask;
    logic [WIDTH-1:0]      w_data;
    logic                  w_ce;
    logic [WIDTH-1:0]      r_data;
    logic                  inv_valid;
    logic [ADDR_WIDTH-1:0] inv_addr;
    logic                  inv_ready;

    modport user (
        output rw_valid, rw_addr, rw_we, w_mask, w_data, w_ce, inv_ready,
        input  rw_ready, r_data, inv_valid, inv_addr
    );

    modport host (
        input  rw_valid, rw_addr, rw_we, w_mask, w_data, w_ce, inv_ready,
        output rw_ready, r_data, inv_valid, inv_addr
    );
endinterface

// File: rtl/snoopy_assoc_cache.sv
// snoopy_assoc_cache: N-way set-associative snooping L1 cache.
//   Reads hit in the cache or refill a whole line from the bus. Writes go
//   through to the bus and update a cached copy in place (no allocation on
//   write miss). Bus snoop invalidations clear matching lines in every way.
//   Victim selection: lowest invalid way, else a per-set round-robin pointer.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   valid/ready     : core request handshake. The core raises valid and holds
//                     it together with addr/we/ce/wmask/wdata until ready,
//                     a one-cycle completion pulse; a new request may be
//                     presented in the cycle after ready.
//   addr, we, ce    : byte address, write select, write chip-enable
//   wmask, wdata    : write byte enables and data
//   rdata           : read data, valid with ready on a read, held otherwise
//   bus             : SystemBus user side
module snoopy_assoc_cache #(
    parameter int WIDTH      = 128,
    parameter int MASKW      = WIDTH / 8,
    parameter int SIZE       = 32768,
    parameter int WAYS       = 2,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    output logic                  ready,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic                  ce,
    input  logic [MASKW-1:0]      wmask,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    SystemBus.user                bus
);
    localparam int SETS    = SIZE / (WIDTH * WAYS);
    localparam int IDX_LSB = $clog2(WIDTH / 8);
    localparam int IDX_W   = $clog2(SETS);
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;
    localparam int PTR_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_REFILL_BUS, S_REFILL_OPER, S_RESP, S_WRITE_BUS, S_WRITE_RESP
    } state_t;

    typedef enum logic [1:0] {
        INV_IDLE, INV_PENDING, INV_OPER
    } inv_state_t;

    state_t     state_q, state_d;
    inv_state_t inv_q, inv_d;

    // Line address of the request in flight (offset bits are never needed).
    logic [ADDR_WIDTH-1:IDX_LSB] line_addr_q;
    logic [WIDTH-1:0]            line_q;
    logic [WIDTH-1:0]            rdata_q;

    logic [TAG_W-1:0] tag_mem   [WAYS][SETS];
    logic [WAYS-1:0]  valid_mem [SETS];
    logic [PTR_W-1:0] ptr_mem   [SETS];

    logic [WAYS-1:0][WIDTH-1:0] ram_rd;
    logic [WAYS-1:0]            ram_we;
    logic [WIDTH-1:0]           ram_wdata;
    logic [MASKW-1:0]           ram_be;
    logic                       ram_rd_en;

    logic [IDX_W-1:0] idx, rd_idx, inv_idx;
    logic [TAG_W-1:0] tag, inv_tag;
    logic [WAYS-1:0]  hit_vec;
    logic             hit;
    logic [PTR_W-1:0] hit_way, victim;
    logic             any_invalid;
    logic             accept;
    logic             unused_bits;

    assign idx     = line_addr_q[TAG_LSB-1:IDX_LSB];
    assign tag     = line_addr_q[ADDR_WIDTH-1:TAG_LSB];
    assign rd_idx  = addr[TAG_LSB-1:IDX_LSB];
    assign inv_idx = bus.inv_addr[TAG_LSB-1:IDX_LSB];
    assign inv_tag = bus.inv_addr[ADDR_WIDTH-1:TAG_LSB];
    assign unused_bits = ^bus.inv_addr[IDX_LSB-1:0];

    // An invalidate that is pending, active, or arriving this very cycle
    // keeps new requests out of the pipeline.
    assign accept = valid && (inv_q == INV_IDLE) && !bus.inv_valid;

    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_mem[idx][w] && (tag_mem[w][idx] == tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = PTR_W'(w);
        end
        hit = |hit_vec;
    end

    always_comb begin
        victim      = ptr_mem[idx];
        any_invalid = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_mem[idx][w]) begin
                victim      = PTR_W'(w);
                any_invalid = 1'b1;
            end
        end
    end

    // Main FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:        if (accept) state_d = we ? S_WRITE_BUS : S_LOOKUP;
            S_LOOKUP:      state_d = hit ? S_IDLE : S_REFILL_BUS;
            S_REFILL_BUS:  if (bus.rw_ready) state_d = S_REFILL_OPER;
            S_REFILL_OPER: state_d = S_RESP;
            S_RESP:        state_d = S_IDLE;
            S_WRITE_BUS:   if (bus.rw_ready) state_d = S_WRITE_RESP;
            S_WRITE_RESP:  state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
    end

    // Invalidate FSM next state; it only acts while the main FSM is idle.
    always_comb begin
        inv_d = inv_q;
        unique case (inv_q)
            INV_IDLE:    if (bus.inv_valid) inv_d = INV_PENDING;
            INV_PENDING: if (state_q == S_IDLE) inv_d = INV_OPER;
            INV_OPER:    inv_d = INV_IDLE;
            default:     inv_d = INV_IDLE;
        endcase
    end

    // Bus outputs are zero outside the BUS states.
    always_comb begin
        bus.rw_valid  = 1'b0;
        bus.rw_we     = 1'b0;
        bus.rw_addr   = '0;
        bus.w_mask    = '0;
        bus.w_data    = '0;
        bus.w_ce      = 1'b0;
        bus.inv_ready = (inv_q == INV_OPER);
        if (state_q == S_REFILL_BUS) begin
            bus.rw_valid = 1'b1;
            bus.rw_addr  = {line_addr_q, {IDX_LSB{1'b0}}};
        end else if (state_q == S_WRITE_BUS) begin
            bus.rw_valid = 1'b1;
            bus.rw_we    = 1'b1;
            bus.rw_addr  = addr;
            bus.w_mask   = wmask;
            bus.w_data   = wdata;
            bus.w_ce     = ce;
        end
    end

    assign ready = ((state_q == S_LOOKUP) && hit) || (state_q == S_RESP) ||
                   (state_q == S_WRITE_RESP);

    // A refill answers from the captured line rather than re-reading the RAM.
    always_comb begin
        rdata = rdata_q;
        if ((state_q == S_LOOKUP) && hit) rdata = ram_rd[hit_way];
        else if (state_q == S_RESP)       rdata = line_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            inv_q       <= INV_IDLE;
            line_addr_q <= '0;
            line_q      <= '0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            inv_q   <= inv_d;
            if ((state_q == S_IDLE) && accept) line_addr_q <= addr[ADDR_WIDTH-1:IDX_LSB];
            if ((state_q == S_REFILL_BUS) && bus.rw_ready) line_q <= bus.r_data;
            if (((state_q == S_LOOKUP) && hit) || (state_q == S_RESP)) rdata_q <= rdata;
        end
    end

    // Valid bits and round-robin pointers. Refill and invalidate never
    // coincide: the invalidate only runs while the main FSM sits in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                ptr_mem[s]   <= '0;
            end
        end else if (state_q == S_REFILL_OPER) begin
            valid_mem[idx][victim] <= 1'b1;
            if (!any_invalid) begin
                ptr_mem[idx] <= (ptr_mem[idx] == PTR_W'(WAYS - 1)) ? '0 : ptr_mem[idx] + 1'b1;
            end
        end else if (inv_q == INV_OPER) begin
            for (int w = 0; w < WAYS; w++) begin
                if (tag_mem[w][inv_idx] == inv_tag) valid_mem[inv_idx][w] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_REFILL_OPER) tag_mem[victim][idx] <= tag;
    end

    assign ram_rd_en = (state_q == S_IDLE) && accept && !we;
    assign ram_wdata = (state_q == S_REFILL_OPER) ? line_q : wdata;
    assign ram_be    = (state_q == S_REFILL_OPER) ? '1 : wmask;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        logic [WIDTH-1:0] mem [SETS];
        logic [WIDTH-1:0] q;

        assign ram_we[g] = ((state_q == S_REFILL_OPER) && (victim == PTR_W'(g))) ||
                           ((state_q == S_WRITE_RESP) && hit_vec[g]);

        always_ff @(posedge clk) begin
            if (ram_rd_en) q <= mem[rd_idx];
            for (int b = 0; b < MASKW; b++) begin
                if (ram_we[g] && ram_be[b]) mem[idx][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end
        end

        assign ram_rd[g] = q;
    end
endmodule

// File: doc/snoopy_assoc_cache.md
# snoopy_assoc_cache

Parametrised N-way set-associative snooping L1 cache sitting between a core-side request port and the shared `SystemBus`, the successor to the direct-mapped read-only cache. Reads are served from the cache with refill on miss. Writes go through to the bus and update any cached copy in place. Bus snoop invalidations clear matching lines in every way, and a per-set round-robin pointer selects the victim on allocation.

## Interface
- `WIDTH`, 128, line width in bits; equals bus data width; multiple of 8.
- `MASKW`, WIDTH/8, byte-mask width.
- `SIZE`, 32768, total data capacity in bits.
- `WAYS`, 2, associativity; power of two, 1..8.
- `ADDR_WIDTH`, 32, byte-address width.
- Derived: SETS = SIZE/(WIDTH·WAYS); IDX_LSB = log2(WIDTH/8); IDX_W = log2(SETS); TAG_LSB = IDX_LSB+IDX_W; TAG_W = ADDR_WIDTH−TAG_LSB.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `valid` in 1: request valid; held with all request fields until `ready`.
- `ready` out 1: one-cycle completion pulse.
- `addr` in ADDR_WIDTH: byte address.
- `we` in 1: 1 = write, 0 = read.
- `ce` in 1: write chip-enable, forwarded to `bus.w_ce`.
- `wmask` in MASKW: write byte enables.
- `wdata` in WIDTH: write data.
- `rdata` out WIDTH: read data, valid when `ready` is high for a read.
- `bus` SystemBus.user modport. Signals used: `rw_valid`/`rw_ready`/`rw_addr`/`rw_we`/`w_mask`/`w_data`/`w_ce`/`r_data`/`inv_valid`/`inv_addr`/`inv_ready`.

## Operation
- Storage:
  - Tags and valid bits are flops, read combinationally.
  - Data is in one synchronous-read, byte-write RAM per way.
  - Each set has one log2(WAYS)-bit round-robin pointer.
- Main FSM: IDLE, LOOKUP, REFILL_BUS, REFILL_OPER, RESP, WRITE_BUS, WRITE_RESP.
  - IDLE:
    - If `valid` && !`we` && inv FSM is INV_IDLE: latch `addr`, issue data reads to all ways at the set, go to LOOKUP.
    - If `valid` && `we` && inv FSM is INV_IDLE: go to WRITE_BUS.
  - LOOKUP:
    - Hit means valid && tag match in some way. On hit: `ready`=1, `rdata` = data of the hitting way, go to IDLE.
    - On miss: go to REFILL_BUS.
  - REFILL_BUS:
    - Drive `rw_valid`=1, `rw_we`=0, `rw_addr` = line-aligned latched address (low IDX_LSB bits zero).
    - On `rw_ready`: capture `r_data`, go to REFILL_OPER.
  - REFILL_OPER: write the captured data, tag and valid=1 into the victim way, then go to RESP.
    - Victim is the lowest-index invalid way.
    - If no way is invalid, the victim is the way at the set pointer, and the pointer then increments mod WAYS.
  - RESP: `ready`=1, `rdata` = captured refill data (bypass), go to IDLE.
  - WRITE_BUS:
    - Drive `rw_valid`=1, `rw_we`=1, `rw_addr`=`addr`, `w_mask`=`wmask`, `w_data`=`wdata`, `w_ce`=`ce`.
    - On `rw_ready`: go to WRITE_RESP.
  - WRITE_RESP: `ready`=1. If `addr` hits a way, write `wdata` into it with byte enables `wmask`; tags, valid bits and pointer are unchanged. Go to IDLE.
  - Write miss: no allocation.
- Inv FSM: INV_IDLE, INV_PENDING, INV_OPER.
  - INV_IDLE: on `inv_valid`, go to INV_PENDING.
  - INV_PENDING: when the main FSM is in IDLE, go to INV_OPER.
  - INV_OPER:
    - Clear valid in every way of the set given by `inv_addr` whose tag matches.
    - `inv_ready`=1 for this one cycle, then go to INV_IDLE.
  - The bus holds `inv_addr` until `inv_ready`.
- Priority:
  - A pending or active invalidate blocks new requests from leaving IDLE.
  - An in-flight read or write is never interrupted; the invalidate waits for it.
- Bus outputs are zero whenever the main FSM is not in a BUS state.

## Timing
- Reset values:
  - Outputs: `ready`=0, `rdata`=0, all `bus` outputs 0, `inv_ready`=0.
  - State: all valid bits 0, all pointers 0, both FSMs idle.
- Reset mid-operation aborts any transaction; the line being refilled is not installed.
- Read hit: `valid` at cycle t, `ready` at t+1.
- Read miss: LOOKUP at t+1, REFILL_BUS at t+2. With `rw_ready` at cycle k, REFILL_OPER is at k+1 and `ready` at k+2.
- Write: WRITE_BUS at t+1. With `rw_ready` at k, `ready` at k+1.
- Invalidate:
  - From idle: `inv_valid` at t, `inv_ready` at t+2.
  - If `inv_valid` arrives in the same cycle as `valid` in IDLE, the invalidate wins and the request starts after INV_OPER.
- Back-to-back: a new request may be accepted in the cycle after `ready`. `ready` is never asserted for two consecutive cycles on the same request.
- `rdata` holds its last value when `ready`=0.

## Test plan
Default parameters apply: SETS=128, index = addr[10:4], tag = addr[31:11].

- **Cold read and re-read:** After reset, read 0x1000 -> `rw_addr`=0x1000, bus returns 0x0123…EF, `ready`+`rdata`=0x0123…EF two cycles after `rw_ready`. Re-reading 0x1000 -> `ready` one cycle after `valid` with the same data and no `rw_valid`.
- **Conflict and round-robin:** Fill 0x1000, then 0x1800, then 0x2000 (all set 0) -> 0x2000 replaces way 0. Read 0x1800 hits; read 0x1000 misses and replaces way 1.
- **Write hit update:** With 0x1000 cached, write addr 0x1000, wmask 0x00F0, wdata byte 4..7 = 0xAA -> bus write with `w_mask`=0x00F0. A following read of 0x1000 hits with bytes 4..7 = 0xAA and all other bytes unchanged.
- **Snoop invalidate:** With 0x1000 cached, `inv_valid`/`inv_addr`=0x1000 -> `inv_ready` two cycles later, and the next read of 0x1000 misses. Invalidating an uncached 0x5000 -> `inv_ready` pulses with no valid-bit change.
- **Invalidate during refill:** `inv_valid` for 0x3000 while a read of 0x3000 waits in REFILL_BUS -> `inv_ready` only after the read's `ready`. The next read of 0x3000 misses.
- **Reset mid-refill:** `rst` pulsed during REFILL_BUS -> `rw_valid`=0 on the next cycle, and the first read of any address afterwards misses.
